// File: rtl/id_ex_operand_stage_if.sv
// Bundle of every signal exchanged by the ID/EX operand stage:
// the decode-side offer, the two forwarding sources and the EX-side result.
// The master drives the i* signals; the slave (the stage itself) drives the o* signals.
interface id_ex_operand_stage_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CNTW = 16
);
   // decode side
   logic            iFlush;
   logic            iValid;
   logic            oReady;
   logic [XLEN-1:0] iPc;
   logic [REGW-1:0] iRs1Addr;
   logic [REGW-1:0] iRs2Addr;
   logic [XLEN-1:0] iRs1Data;
   logic [XLEN-1:0] iRs2Data;
   logic [XLEN-1:0] iImm;
   logic            iUsePcA;
   logic            iUseImmB;
   logic [3:0]      iAluOp;
   logic [REGW-1:0] iRdAddr;
   logic            iRegWrite;
   logic            iMemRead;
   logic            iMemWrite;
   logic            iIsBranch;

   // forwarding sources from later pipeline stages
   logic            iExMemRegWrite;
   logic [REGW-1:0] iExMemRd;
   logic [XLEN-1:0] iExMemData;
   logic            iMemWbRegWrite;
   logic [REGW-1:0] iMemWbRd;
   logic [XLEN-1:0] iMemWbData;

   // EX side
   logic            oValid;
   logic            iReady;
   logic [XLEN-1:0] oDataA;
   logic [XLEN-1:0] oDataB;
   logic [XLEN-1:0] oStoreData;
   logic [3:0]      oAluOp;
   logic [XLEN-1:0] oPc;
   logic [REGW-1:0] oRdAddr;
   logic            oRegWrite;
   logic            oMemRead;
   logic            oMemWrite;
   logic            oIsBranch;
   logic [CNTW-1:0] oBubbleCnt;

   modport master (
      output iFlush, iValid, iPc, iRs1Addr, iRs2Addr, iRs1Data, iRs2Data, iImm,
             iUsePcA, iUseImmB, iAluOp, iRdAddr, iRegWrite, iMemRead, iMemWrite,
             iIsBranch, iExMemRegWrite, iExMemRd, iExMemData, iMemWbRegWrite,
             iMemWbRd, iMemWbData, iReady,
      input  oReady, oValid, oDataA, oDataB, oStoreData, oAluOp, oPc, oRdAddr,
             oRegWrite, oMemRead, oMemWrite, oIsBranch, oBubbleCnt
   );

   modport slave (
      input  iFlush, iValid, iPc, iRs1Addr, iRs2Addr, iRs1Data, iRs2Data, iImm,
             iUsePcA, iUseImmB, iAluOp, iRdAddr, iRegWrite, iMemRead, iMemWrite,
             iIsBranch, iExMemRegWrite, iExMemRd, iExMemData, iMemWbRegWrite,
             iMemWbRd, iMemWbData, iReady,
      output oReady, oValid, oDataA, oDataB, oStoreData, oAluOp, oPc, oRdAddr,
             oRegWrite, oMemRead, oMemWrite, oIsBranch, oBubbleCnt
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the RV32I ALU.
// Latches the decoded instruction, forwards EX/MEM and MEM/WB results onto the
// source operands, stalls decode for one cycle on a load-use dependency and
// keeps forwarded operand values alive while EX is stalled.
// The XLEN/REGW/CNTW parameters must match those of the connected interface.
module id_ex_operand_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic                  iClk,
   input  logic                  iRstN,
   id_ex_operand_stage_if.slave  bus
);

   // registered instruction fields
   logic            validReg;
   logic [XLEN-1:0] pcReg;
   logic [REGW-1:0] rs1AddrReg;
   logic [REGW-1:0] rs2AddrReg;
   logic [XLEN-1:0] rs1Reg;
   logic [XLEN-1:0] rs2Reg;
   logic [XLEN-1:0] immReg;
   logic            usePcAReg;
   logic            useImmBReg;
   logic [3:0]      aluOpReg;
   logic [REGW-1:0] rdAddrReg;
   logic            regWriteReg;
   logic            memReadReg;
   logic            memWriteReg;
   logic            isBranchReg;
   logic [CNTW-1:0] bubbleCntReg;
   logic [CNTW-1:0] bubbleCntNext;

   // handshake / hazard terms
   logic rs1Hit;
   logic rs2Hit;
   logic hazard;
   logic stageReady;
   logic accept;
   logic xferOut;
   logic loadEn;
   logic holdEn;
   logic bubbleEn;

   // forwarding: index 0 is rs1, index 1 is rs2
   logic [REGW-1:0] srcAddr [2];
   logic [XLEN-1:0] srcReg  [2];
   logic [XLEN-1:0] fwdData [2];

   assign srcAddr[0] = rs1AddrReg;
   assign srcAddr[1] = rs2AddrReg;
   assign srcReg[0]  = rs1Reg;
   assign srcReg[1]  = rs2Reg;

   // One forwarding mux per source operand; EX/MEM is the younger result and wins.
   // x0 is never forwarded because it is hard-wired to zero in the register file.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gFwd
         logic [XLEN-1:0] fwdSel;

         // Select the newest in-flight value for this source register
         always_comb begin
            fwdSel = srcReg[gi];
            if (srcAddr[gi] != '0) begin
               if (bus.iExMemRegWrite && (bus.iExMemRd == srcAddr[gi])) begin
                  fwdSel = bus.iExMemData;
               end else if (bus.iMemWbRegWrite && (bus.iMemWbRd == srcAddr[gi])) begin
                  fwdSel = bus.iMemWbData;
               end
            end
         end

         assign fwdData[gi] = fwdSel;
      end
   endgenerate

   // A held load whose destination is consumed by the instruction on the
   // decode bus cannot forward in time, so decode is held back one cycle.
   // rs2 counts as consumed when it drives the ALU or is the store data.
   assign rs1Hit     = (rdAddrReg == bus.iRs1Addr) && !bus.iUsePcA;
   assign rs2Hit     = (rdAddrReg == bus.iRs2Addr) && (!bus.iUseImmB || bus.iMemWrite);
   assign hazard     = validReg && memReadReg && (rdAddrReg != '0) && (rs1Hit || rs2Hit);

   assign stageReady = (!validReg || bus.iReady) && !hazard;
   assign accept     = bus.iValid && stageReady;
   assign xferOut    = validReg && bus.iReady;

   // A flush discards both the held and the incoming instruction.
   assign loadEn     = accept && !bus.iFlush;
   assign holdEn     = validReg && !xferOut && !bus.iFlush;
   assign bubbleEn   = !bus.iFlush && !accept && xferOut && hazard && bus.iValid;

   // Saturating increment of the bubble counter
   always_comb begin
      bubbleCntNext = bubbleCntReg;
      if (bubbleEn && !(&bubbleCntReg)) begin
         bubbleCntNext = bubbleCntReg + CNTW'(1);
      end
   end

   // EMPTY/FULL occupancy: flush drops, accept fills, transfer drains
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         validReg <= 1'b0;
      end else if (bus.iFlush) begin
         validReg <= 1'b0;
      end else if (accept) begin
         validReg <= 1'b1;
      end else if (xferOut) begin
         validReg <= 1'b0;
      end
   end

   // Capture the non-operand instruction fields when a new instruction is accepted
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         pcReg       <= '0;
         rs1AddrReg  <= '0;
         rs2AddrReg  <= '0;
         immReg      <= '0;
         usePcAReg   <= 1'b0;
         useImmBReg  <= 1'b0;
         aluOpReg    <= '0;
         rdAddrReg   <= '0;
         regWriteReg <= 1'b0;
         memReadReg  <= 1'b0;
         memWriteReg <= 1'b0;
         isBranchReg <= 1'b0;
      end else if (loadEn) begin
         pcReg       <= bus.iPc;
         rs1AddrReg  <= bus.iRs1Addr;
         rs2AddrReg  <= bus.iRs2Addr;
         immReg      <= bus.iImm;
         usePcAReg   <= bus.iUsePcA;
         useImmBReg  <= bus.iUseImmB;
         aluOpReg    <= bus.iAluOp;
         rdAddrReg   <= bus.iRdAddr;
         regWriteReg <= bus.iRegWrite;
         memReadReg  <= bus.iMemRead;
         memWriteReg <= bus.iMemWrite;
         isBranchReg <= bus.iIsBranch;
      end
   end

   // Source operands: load from the register file, or while stalled absorb the
   // forwarded value so it survives the producer leaving the forwarding window
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         rs1Reg <= '0;
         rs2Reg <= '0;
      end else if (loadEn) begin
         rs1Reg <= bus.iRs1Data;
         rs2Reg <= bus.iRs2Data;
      end else if (holdEn) begin
         rs1Reg <= fwdData[0];
         rs2Reg <= fwdData[1];
      end
   end

   // Count load-use bubbles
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         bubbleCntReg <= '0;
      end else begin
         bubbleCntReg <= bubbleCntNext;
      end
   end

   // Operand muxing is pure selection from registered fields and forwards
   assign bus.oReady     = stageReady;
   assign bus.oValid     = validReg;
   assign bus.oDataA     = usePcAReg  ? pcReg  : fwdData[0];
   assign bus.oDataB     = useImmBReg ? immReg : fwdData[1];
   assign bus.oStoreData = fwdData[1];
   assign bus.oAluOp     = aluOpReg;
   assign bus.oPc        = pcReg;
   assign bus.oRdAddr    = rdAddrReg;
   assign bus.oRegWrite  = regWriteReg;
   assign bus.oMemRead   = memReadReg;
   assign bus.oMemWrite  = memWriteReg;
   assign bus.oIsBranch  = isBranchReg;
   assign bus.oBubbleCnt = bubbleCntReg;

endmodule
